// File: rtl/fifo_gen.sv
// rtl/fifo_gen.sv - parametrised button-driven FIFO with press-edge detect and slot scan display
// Optional almost-full/almost-empty flags: define FIFO_GEN_ALMOST_FLAGS_EN.
module fifo_gen #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int SCAN_BITS = 16
`ifdef FIFO_GEN_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL  = DEPTH - 1,
    parameter int AE_LEVEL  = 1
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in,
    input  logic                       enq,
    input  logic                       deq,
    output logic [WIDTH-1:0]           out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   an,
    output logic [WIDTH-1:0]           seg,
`ifdef FIFO_GEN_ALMOST_FLAGS_EN
    output logic                       almost_full,
    output logic                       almost_empty,
`endif
    output logic                       disp_vld
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 enq_q, enq_d, deq_q, deq_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [AW-1:0]        an_q, an_d;
    logic                 enq_p, deq_p, do_enq, do_deq;
    logic [AW-1:0]        disp_off;

    // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
    always_comb begin
        enq_p  = enq & ~enq_q;
        deq_p  = deq & ~deq_q;
        do_deq = ~rst & deq_p & (count_q != '0);
        do_enq = ~rst & enq_p & ((count_q != FULL_CNT) | do_deq);

        enq_d    = enq;
        deq_d    = deq;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        scan_d   = scan_q + SCAN_BITS'(1);
        an_d     = (&scan_q) ? an_q + AW'(1) : an_q;

        if (rst) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            out_d    = '0;
            scan_d   = '0;
            an_d     = '0;
        end else begin
            if (do_deq) begin
                out_d    = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_enq) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        enq_q    <= enq_d;
        deq_q    <= deq_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        out_q    <= out_d;
        scan_q   <= scan_d;
        an_q     <= an_d;
        if (do_enq) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    // Slot is valid when its distance past the head is inside the occupancy.
    assign disp_off = an_q - rd_ptr_q;
    assign out      = out_q;
    assign count    = count_q;
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign an       = an_q;
    assign seg      = mem_q[an_q];
    assign disp_vld = full | ({1'b0, disp_off} < count_q);

`ifdef FIFO_GEN_ALMOST_FLAGS_EN
    localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
`endif
endmodule

// File: tb/tb_fifo_gen.sv
// tb/tb_fifo_gen.sv - self-checking bench for fifo_gen against a queue-based model
module tb_fifo_gen;
    localparam int W  = 4;
    localparam int D  = 8;
    localparam int SB = 1;

    logic       clk = 0;
    logic       rst = 1;
    logic [3:0] din = '0;
    logic       enq = 0;
    logic       deq = 0;
    logic [3:0] dout;
    logic       full, empty, disp_vld;
    logic [3:0] count;
    logic [2:0] an;
    logic [3:0] seg;
`ifdef FIFO_GEN_ALMOST_FLAGS_EN
    logic       almost_full, almost_empty;
`endif

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 0;

    fifo_gen #(.WIDTH(W), .DEPTH(D), .SCAN_BITS(SB)) dut (
        .clk(clk), .rst(rst), .in(din), .enq(enq), .deq(deq),
        .out(dout), .full(full), .empty(empty), .count(count),
        .an(an), .seg(seg),
`ifdef FIFO_GEN_ALMOST_FLAGS_EN
        .almost_full(almost_full), .almost_empty(almost_empty),
`endif
        .disp_vld(disp_vld)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of entries plus the physical slot image for the display.
    logic [3:0] q_m[$];
    logic [3:0] mem_m [D];
    bit         written_m [D];
    int         head_m = 0, wr_m = 0, scan_m = 0, an_m = 0;
    logic [3:0] out_m = '0;
    logic       pe_m = 0, pd_m = 0;

    always @(posedge clk) begin
        bit ep, dp, did_d, did_e;
        if (rst) begin
            q_m.delete();
            head_m = 0; wr_m = 0; scan_m = 0; an_m = 0; out_m = '0;
        end else begin
            ep    = enq && !pe_m;
            dp    = deq && !pd_m;
            did_d = dp && (q_m.size() > 0);
            did_e = ep && ((q_m.size() < D) || did_d);
            if (did_d) begin
                out_m  = q_m.pop_front();
                head_m = (head_m + 1) % D;
            end
            if (did_e) begin
                q_m.push_back(din);
                mem_m[wr_m]     = din;
                written_m[wr_m] = 1;
                wr_m            = (wr_m + 1) % D;
            end
            if (scan_m == (1 << SB) - 1) an_m = (an_m + 1) % D;
            scan_m = (scan_m + 1) % (1 << SB);
        end
        pe_m = enq;
        pd_m = deq;
    end

    function automatic bit slot_valid(int s);
        for (int i = 0; i < q_m.size(); i++)
            if ((head_m + i) % D == s) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count", 32'(count), 32'(q_m.size()));
            chk("m_full", 32'(full), 32'(q_m.size() == D));
            chk("m_empty", 32'(empty), 32'(q_m.size() == 0));
            chk("m_out", 32'(dout), 32'(out_m));
            chk("m_an", 32'(an), 32'(an_m));
            chk("m_disp_vld", 32'(disp_vld), 32'(slot_valid(an_m)));
            if (written_m[an_m]) chk("m_seg", 32'(seg), 32'(mem_m[an_m]));
`ifdef FIFO_GEN_ALMOST_FLAGS_EN
            chk("m_afull", 32'(almost_full), 32'(q_m.size() >= D - 1));
            chk("m_aempty", 32'(almost_empty), 32'(q_m.size() <= 1));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1; step(n); rst = 0;
    endtask

    task automatic press_enq(input logic [3:0] d, input int hold);
        din = d; enq = 1; step(hold); enq = 0; step(1);
    endtask

    task automatic press_deq(input int hold);
        deq = 1; step(hold); deq = 0; step(1);
    endtask

    task automatic press_both(input logic [3:0] d);
        din = d; enq = 1; deq = 1; step(1); enq = 0; deq = 0; step(1);
    endtask

    initial begin
        int hi;
        do_reset(2);
        chk_en = 1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_out", 32'(dout), 0);
        chk("rst_an", 32'(an), 0);
        chk("rst_disp_vld", 32'(disp_vld), 0);

        // Held presses count once.
        press_enq(4'h6, 5);
        press_enq(4'h9, 5);
        chk("t1_count2", 32'(count), 2);
        chk("t1_empty0", 32'(empty), 0);
        press_deq(3);
        chk("t1_out6", 32'(dout), 6);
        chk("t1_count1", 32'(count), 1);

        // Fill, overflow, drain, underflow.
        do_reset(1);
        for (int i = 0; i < 8; i++) press_enq(4'(i), 1);
        chk("t2_full", 32'(full), 1);
        chk("t2_count8", 32'(count), 8);
        press_enq(4'hB, 1);
        chk("t2_ovf_count", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            press_deq(1);
            chk("t2_drain_out", 32'(dout), 32'(i));
        end
        chk("t2_empty", 32'(empty), 1);
        press_deq(1);
        chk("t2_udf_out", 32'(dout), 7);

        // Simultaneous enq/deq when full and when empty.
        do_reset(1);
        for (int i = 0; i < 8; i++) press_enq(4'(i), 1);
        press_both(4'hC);
        chk("t3_full_out", 32'(dout), 0);
        chk("t3_full_count", 32'(count), 8);
        chk("t3_full_flag", 32'(full), 1);
        for (int i = 0; i < 7; i++) press_deq(1);
        chk("t3_out7", 32'(dout), 7);
        press_deq(1);
        chk("t3_outC", 32'(dout), 32'hC);
        press_both(4'hD);
        chk("t3_empty_count", 32'(count), 1);
        chk("t3_empty_out", 32'(dout), 32'hC);
        press_deq(1);
        chk("t3_outD", 32'(dout), 32'hD);

        // Pointer wrap.
        do_reset(1);
        for (int i = 1; i <= 5; i++) press_enq(4'(i), 1);
        for (int i = 0; i < 4; i++) press_deq(1);
        chk("t4_out4", 32'(dout), 4);
        for (int i = 6; i <= 11; i++) press_enq(4'(i), 1);
        chk("t4_count7", 32'(count), 7);
        for (int i = 0; i < 7; i++) begin
            press_deq(1);
            chk("t4_wrap_out", 32'(dout), 32'(5 + i));
        end

        // Display scan over slots 1..3 occupied.
        do_reset(1);
        press_enq(4'hA, 1); press_enq(4'hB, 1); press_enq(4'hC, 1); press_enq(4'hD, 1);
        press_deq(1);
        hi = 0;
        for (int c = 0; c < 16; c++) begin
            if (disp_vld) hi++;
            if (an == 3'd2) chk("t5_seg2", 32'(seg), 32'hC);
            step(1);
        end
        chk("t5_vld_cycles", 32'(hi), 6);

        // Button held through reset fires nothing.
        enq = 1; din = 4'h3;
        do_reset(2);
        step(3); enq = 0; step(1);
        chk("t6_hold_count", 32'(count), 0);

        // Reset mid-operation.
        press_enq(4'h5, 1); press_enq(4'h6, 1); press_enq(4'h7, 1);
        press_deq(1);
        chk("t6_pre_out", 32'(dout), 5);
        do_reset(1);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_out", 32'(dout), 0);

`ifdef FIFO_GEN_ALMOST_FLAGS_EN
        for (int i = 0; i < 7; i++) press_enq(4'(i), 1);
        chk("af_at7", 32'(almost_full), 1);
        for (int i = 0; i < 6; i++) press_deq(1);
        chk("ae_at1", 32'(almost_empty), 1);
`endif
        step(2);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
